// File: rtl/nios_debug_ocimem_pkg.sv
// Shared types and jdo field layout for the OCI memory arbiter.
package nios_debug_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_JTAG = 1'b0,
    OWN_CPU  = 1'b1
  } owner_e;

  localparam int JDO_W         = 38;
  localparam int JDO_RD_BIT    = 17;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 26;

  // Extract the 32-bit write payload carried by an ocimem_b command.
  function automatic logic [31:0] jdo_wdata(input logic [JDO_W-1:0] jdo);
    return jdo[JDO_WDATA_LSB +: 32];
  endfunction

endpackage

// File: rtl/nios_debug_ocimem_arbiter_if.sv
// Bundles the JTAG strobes, CPU slave port, RAM port and monitor outputs.
interface nios_debug_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [37:0]       jdo;

  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_writedata;
  logic              cpu_waitrequest;
  logic [DATA_W-1:0] cpu_readdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mon_dreg;
  logic              jtag_done;
  logic              jtag_overrun;

  // Arbiter side.
  modport slave (
    input  take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b, jdo,
    input  cpu_read, cpu_write, cpu_address, cpu_writedata,
    output cpu_waitrequest, cpu_readdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output mon_dreg, jtag_done, jtag_overrun
  );

  // Environment side: debug slave, CPU master and RAM.
  modport master (
    output take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b, jdo,
    output cpu_read, cpu_write, cpu_address, cpu_writedata,
    input  cpu_waitrequest, cpu_readdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  mon_dreg, jtag_done, jtag_overrun
  );
endinterface

// File: rtl/nios_debug_jcmd_buf.sv
// One-entry JTAG command buffer: strobe decode, auto-incrementing address
// and sticky overrun flag for commands that arrive while the entry is busy.
module nios_debug_jcmd_buf
  import nios_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_act_a,
  input  logic              i_no_act_a,
  input  logic              i_act_b,
  input  logic [JDO_W-1:0]  i_jdo,
  input  logic              i_drain,
  output logic              o_pend,
  output logic              o_we,
  output logic [31:0]       o_wdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_overrun
);

  logic              w_strobe;
  logic              w_load;
  logic              w_issue;
  logic              w_we;
  logic              w_busy;
  logic              w_accept;
  logic [ADDR_W-1:0] w_load_addr;
  logic              w_unused_jdo;

  logic              r_pend;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overrun;

  assign w_load_addr  = i_jdo[JDO_ADDR_LSB +: ADDR_W];
  // jdo bits outside the address/data/read fields carry nothing for this block.
  assign w_unused_jdo = ^{i_jdo[37:35], i_jdo[2:0]};

  assign w_strobe = i_act_a | i_act_b | i_no_act_a;
  // The entry frees up in the same cycle it is drained, so a new strobe then is safe.
  assign w_busy   = r_pend & ~i_drain;
  assign w_accept = w_strobe & ~w_busy;

  // Collapse coincident strobes into one command: ocimem_a > ocimem_b > no_action_a.
  always_comb begin
    w_load  = 1'b0;
    w_issue = 1'b0;
    w_we    = 1'b0;
    if (i_act_a) begin
      w_load  = 1'b1;
      w_issue = i_jdo[JDO_RD_BIT];
    end else if (i_act_b) begin
      w_issue = 1'b1;
      w_we    = 1'b1;
    end else if (i_no_act_a) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
  end

  // Buffer entry, JTAG address (load beats increment) and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= 32'h0000_0000;
      r_addr    <= {ADDR_W{1'b0}};
      r_overrun <= 1'b0;
    end else begin
      if (w_strobe && w_busy) begin
        r_overrun <= 1'b1;
      end

      if (w_accept && w_issue) begin
        r_pend <= 1'b1;
        r_we   <= w_we;
        if (w_we) begin
          r_wdata <= jdo_wdata(i_jdo);
        end
      end else if (i_drain) begin
        r_pend <= 1'b0;
      end

      if (w_accept && w_load) begin
        r_addr <= w_load_addr;
      end else if (i_drain) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_we      = r_we;
  assign o_wdata   = r_wdata;
  assign o_addr    = r_addr;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/nios_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between buffered JTAG commands and
// CPU debug-mode accesses. Each access takes IDLE -> ACCESS -> CAPTURE.
module nios_debug_ocimem_arbiter
  import nios_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  nios_debug_ocimem_arbiter_if.slave  bus
);

  logic              w_j_pend;
  logic              w_j_we;
  logic [31:0]       w_j_wdata;
  logic [ADDR_W-1:0] w_j_addr;
  logic              w_cpu_req;
  logic              w_grant_valid;
  owner_e            w_grant;
  logic              w_drain;
  logic              w_cap_cpu;
  logic              w_cap_jtag_rd;

  state_e            r_state;
  owner_e            r_owner;
  owner_e            r_last_owner;
  logic              r_acc_we;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_jtag_done;
  logic [DATA_W-1:0] r_mon_dreg;

  nios_debug_jcmd_buf #(
    .ADDR_W (ADDR_W)
  ) u_jbuf (
    .clk        (clk),
    .reset      (reset),
    .i_act_a    (bus.take_action_ocimem_a),
    .i_no_act_a (bus.take_no_action_ocimem_a),
    .i_act_b    (bus.take_action_ocimem_b),
    .i_jdo      (bus.jdo),
    .i_drain    (w_drain),
    .o_pend     (w_j_pend),
    .o_we       (w_j_we),
    .o_wdata    (w_j_wdata),
    .o_addr     (w_j_addr),
    .o_overrun  (bus.jtag_overrun)
  );

  assign w_cpu_req = bus.cpu_read | bus.cpu_write;
  // The JTAG entry is consumed during its ACCESS cycle.
  assign w_drain   = (r_state == ACCESS) && (r_owner == OWN_JTAG);

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    w_grant_valid = w_j_pend | w_cpu_req;
    w_grant       = OWN_CPU;
    if (w_j_pend && w_cpu_req) begin
      w_grant = (r_last_owner == OWN_CPU) ? OWN_JTAG : OWN_CPU;
    end else if (w_j_pend) begin
      w_grant = OWN_JTAG;
    end else begin
      w_grant = OWN_CPU;
    end
  end

  // Access sequencer with registered RAM port, done pulse and monitor register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_CPU;
      r_acc_we     <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= {ADDR_W{1'b0}};
      r_ram_wdata  <= {DATA_W{1'b0}};
      r_jtag_done  <= 1'b0;
      r_mon_dreg   <= {DATA_W{1'b0}};
    end else begin
      r_jtag_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state      <= ACCESS;
            r_owner      <= w_grant;
            r_last_owner <= w_grant;
            r_ram_en     <= 1'b1;
            if (w_grant == OWN_JTAG) begin
              r_acc_we    <= w_j_we;
              r_ram_we    <= w_j_we;
              r_ram_addr  <= w_j_addr;
              r_ram_wdata <= w_j_wdata;
            end else begin
              // A simultaneous read+write request is taken as a write.
              r_acc_we    <= bus.cpu_write;
              r_ram_we    <= bus.cpu_write;
              r_ram_addr  <= bus.cpu_address;
              r_ram_wdata <= bus.cpu_writedata;
            end
          end
        end
        ACCESS: begin
          r_state     <= CAPTURE;
          r_ram_en    <= 1'b0;
          r_ram_we    <= 1'b0;
          r_jtag_done <= (r_owner == OWN_JTAG);
        end
        CAPTURE: begin
          r_state <= IDLE;
          if (w_cap_jtag_rd) begin
            r_mon_dreg <= bus.ram_rdata;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign w_cap_cpu     = (r_state == CAPTURE) && (r_owner == OWN_CPU);
  assign w_cap_jtag_rd = (r_state == CAPTURE) && (r_owner == OWN_JTAG) && !r_acc_we;

  // Read data arrives one cycle after ACCESS, so it is forwarded during CAPTURE.
  assign bus.cpu_waitrequest = w_cpu_req & ~w_cap_cpu;
  assign bus.cpu_readdata    = (w_cap_cpu && !r_acc_we) ? bus.ram_rdata : {DATA_W{1'b0}};
  assign bus.mon_dreg        = w_cap_jtag_rd ? bus.ram_rdata : r_mon_dreg;
  assign bus.jtag_done       = r_jtag_done;
  assign bus.ram_en          = r_ram_en;
  assign bus.ram_we          = r_ram_we;
  assign bus.ram_addr        = r_ram_addr;
  assign bus.ram_wdata       = r_ram_wdata;

endmodule

// File: tb/tb_nios_debug_ocimem_arbiter.sv
// Directed bench for the OCI memory arbiter with a behavioural 1-cycle RAM.
module tb_nios_debug_ocimem_arbiter;
  import nios_debug_ocimem_pkg::*;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_debug_ocimem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

  nios_debug_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  int          wr_count = 0;
  logic [7:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  // Single-port RAM with 1-cycle read latency plus a bench preload port.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        wr_count          <= wr_count + 1;
        last_wr_addr      <= bus.ram_addr;
        last_wr_data      <= bus.ram_wdata;
      end
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] v;
    v = 38'h0;
    v[33:26] = addr;
    v[17] = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v;
    v = 38'h0;
    v[34:3] = d;
    return v;
  endfunction

  // Hard stop if the directed sequence somehow stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          done_cnt;
  int          n_acc;
  logic        exp_cpu;
  int          wr_snap;
  logic        got;

  initial begin
    reset = 1'b1;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.jdo = 38'h0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_address = 8'h00;
    bus.cpu_writedata = 32'h0;
    bd_we = 1'b0; bd_addr = 8'h00; bd_data = 32'h0;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en",    32'(bus.ram_en), 32'h0);
    check("rst_ram_we",    32'(bus.ram_we), 32'h0);
    check("rst_ram_addr",  32'(bus.ram_addr), 32'h0);
    check("rst_ram_wdata", bus.ram_wdata, 32'h0);
    check("rst_mon_dreg",  bus.mon_dreg, 32'h0);
    check("rst_cpu_rdata", bus.cpu_readdata, 32'h0);
    check("rst_done",      32'(bus.jtag_done), 32'h0);
    check("rst_overrun",   32'(bus.jtag_overrun), 32'h0);
    check("rst_waitreq0",  32'(bus.cpu_waitrequest), 32'h0);
    bus.cpu_read = 1'b1;
    #1;
    check("rst_waitreq_level", 32'(bus.cpu_waitrequest), 32'h1);
    bus.cpu_read = 1'b0;
    step();
    reset = 1'b0;
    preload(8'h10, 32'hDEAD_BEEF);
    preload(8'h05, 32'h0505_A5A5);

    // ---- JTAG read at 0x10: ram_en at c2, data + done at c3 ----
    bus.take_action_ocimem_a = 1'b1;
    bus.jdo = jdo_a(8'h10, 1'b1);
    step();
    bus.take_action_ocimem_a = 1'b0;
    step();
    @(negedge clk);
    check("t1_ram_en_c2",   32'(bus.ram_en), 32'h1);
    check("t1_ram_addr_c2", 32'(bus.ram_addr), 32'h10);
    check("t1_ram_we_c2",   32'(bus.ram_we), 32'h0);
    step();
    @(negedge clk);
    check("t1_done_c3",     32'(bus.jtag_done), 32'h1);
    check("t1_mon_c3",      bus.mon_dreg, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    check("t1_done_c4",     32'(bus.jtag_done), 32'h0);
    check("t1_mon_hold",    bus.mon_dreg, 32'hDEAD_BEEF);
    check("t1_jaddr",       32'(dut.w_j_addr), 32'h11);
    step();

    // ---- address load to 0xFE, then three writes wrapping past 0xFF ----
    done_cnt = 0;
    bus.take_action_ocimem_a = 1'b1;
    bus.jdo = jdo_a(8'hFE, 1'b0);
    @(negedge clk);
    if (bus.jtag_done) done_cnt++;
    step();
    bus.take_action_ocimem_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.take_action_ocimem_b = 1'b1;
      bus.jdo = jdo_b(32'(i + 1));
      @(negedge clk);
      if (bus.jtag_done) done_cnt++;
      step();
      bus.take_action_ocimem_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (bus.jtag_done) done_cnt++;
        step();
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bus.jtag_done) done_cnt++;
      step();
    end
    check("t2_done_cnt", 32'(done_cnt), 32'd3);
    check("t2_mem_fe",   mem[8'hFE], 32'h1);
    check("t2_mem_ff",   mem[8'hFF], 32'h2);
    check("t2_mem_00",   mem[8'h00], 32'h3);
    check("t2_jaddr",    32'(dut.w_j_addr), 32'h01);

    // ---- JTAG and CPU requests meet in the same IDLE cycle: JTAG first ----
    do_reset();
    bus.take_action_ocimem_a = 1'b1;
    bus.jdo = jdo_a(8'h10, 1'b1);
    step();
    bus.take_action_ocimem_a = 1'b0;
    bus.cpu_read = 1'b1;
    bus.cpu_address = 8'h05;
    step();
    @(negedge clk);
    check("t3_jtag_first_en",   32'(bus.ram_en), 32'h1);
    check("t3_jtag_first_addr", 32'(bus.ram_addr), 32'h10);
    step();
    @(negedge clk);
    check("t3_done_c3",    32'(bus.jtag_done), 32'h1);
    check("t3_wait_c3",    32'(bus.cpu_waitrequest), 32'h1);
    step();
    step();
    @(negedge clk);
    check("t3_cpu_en_c5",   32'(bus.ram_en), 32'h1);
    check("t3_cpu_addr_c5", 32'(bus.ram_addr), 32'h05);
    check("t3_wait_c5",     32'(bus.cpu_waitrequest), 32'h1);
    step();
    @(negedge clk);
    check("t3_wait_c6",  32'(bus.cpu_waitrequest), 32'h0);
    check("t3_rdata_c6", bus.cpu_readdata, 32'h0505_A5A5);
    step();
    bus.cpu_read = 1'b0;
    step();

    // ---- continuous CPU reads and a JTAG strobe every cycle ----
    do_reset();
    bus.cpu_read = 1'b1;
    bus.cpu_address = 8'h40;
    bus.take_no_action_ocimem_a = 1'b1;
    exp_cpu = 1'b1;
    n_acc = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      @(negedge clk);
      if (k == 1) check("t4_overrun_c1", 32'(bus.jtag_overrun), 32'h0);
      if (k == 2) check("t4_overrun_c2", 32'(bus.jtag_overrun), 32'h1);
      if (bus.ram_en === 1'b1) begin
        check("t4_grant_owner", 32'(bus.ram_addr == 8'h40), 32'(exp_cpu));
        exp_cpu = ~exp_cpu;
        n_acc++;
      end
    end
    check("t4_n_access", 32'(n_acc), 32'd5);
    step();
    bus.cpu_read = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("t4_overrun_sticky", 32'(bus.jtag_overrun), 32'h1);
    step();

    // ---- reset during the ACCESS cycle of a CPU write ----
    do_reset();
    bus.cpu_write = 1'b1;
    bus.cpu_address = 8'h20;
    bus.cpu_writedata = 32'hCAFE_0000;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("t5_access_we", 32'(bus.ram_we), 32'h1);
    step();
    @(negedge clk);
    wr_snap = wr_count;
    check("t5_rst_en",    32'(bus.ram_en), 32'h0);
    check("t5_rst_we",    32'(bus.ram_we), 32'h0);
    check("t5_rst_addr",  32'(bus.ram_addr), 32'h0);
    check("t5_rst_wdata", bus.ram_wdata, 32'h0);
    check("t5_rst_wait",  32'(bus.cpu_waitrequest), 32'h1);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_no_write_after_rst", 32'(wr_count), 32'(wr_snap));
    check("t5_wait_held",          32'(bus.cpu_waitrequest), 32'h1);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      @(negedge clk);
      if (bus.cpu_waitrequest === 1'b0) got = 1'b1;
    end
    check("t5_wait_fall",   32'(got), 32'h1);
    check("t5_write_count", 32'(wr_count), 32'(wr_snap + 1));
    check("t5_write_addr",  32'(last_wr_addr), 32'h20);
    check("t5_write_data",  last_wr_data, 32'hCAFE_0000);
    step();
    bus.cpu_write = 1'b0;
    step();

    // ---- no requests: RAM stays idle ----
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      check("t6_idle_en",    32'(bus.ram_en), 32'h0);
      check("t6_idle_state", 32'(dut.r_state), 32'(IDLE));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
